// File: rtl/gene_unpack_stream.sv
// rtl/gene_unpack_stream.sv - 2-bit nucleotide word to ASCII character stream expander
// Optional per-base character counters: define GENE_UNPACK_STATS_EN.
module gene_unpack_stream #(
    parameter int CODES_IN  = 16,
    parameter int CHARS_OUT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*CODES_IN-1:0]         in_data,
    input  logic                          in_last,
    input  logic [$clog2(CODES_IN+1)-1:0] in_count,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*CHARS_OUT-1:0]        out_data,
    output logic [CHARS_OUT-1:0]          out_keep,
    output logic                          out_last
`ifdef GENE_UNPACK_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [31:0]                   cnt_a,
    output logic [31:0]                   cnt_c,
    output logic [31:0]                   cnt_g,
    output logic [31:0]                   cnt_t
`endif
);

    localparam int NB = CODES_IN / CHARS_OUT;
    localparam int CW = $clog2(CODES_IN + 1);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {EMPTY, LOADED} state_t;

    state_t                  state;
    logic [2*CODES_IN-1:0]   word_q;
    logic [CW-1:0]           n_q;
    logic                    last_q;
    logic [BW-1:0]           beat_q;

    logic [CW-1:0]           eff_n;
    int                      rem_cur;
    int                      rem_nxt;
    logic                    final_beat;
    logic                    in_hs;
    logic                    out_hs;
    logic [9*CHARS_OUT-1:0]  beat_load;
    logic [9*CHARS_OUT-1:0]  beat_next;

    function automatic logic [7:0] code2ascii(input logic [1:0] c);
        case (c)
            2'b00:   return 8'h41;
            2'b01:   return 8'h43;
            2'b10:   return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

    // Returns {keep, data} for beat b of word w, with rem codes left from that beat onward.
    function automatic logic [9*CHARS_OUT-1:0] make_beat(input logic [2*CODES_IN-1:0] w,
                                                         input int rem, input int b);
        logic [8*CHARS_OUT-1:0] d;
        logic [CHARS_OUT-1:0]   k;
        d = '0;
        k = '0;
        for (int i = 0; i < CHARS_OUT; i++) begin
            if (i < rem) begin
                k[CHARS_OUT-1-i]            = 1'b1;
                d[8*(CHARS_OUT-1-i) +: 8]   = code2ascii(w[2*(CODES_IN-1-(b*CHARS_OUT+i)) +: 2]);
            end
        end
        return {k, d};
    endfunction

    always_comb begin
        eff_n = CW'(CODES_IN);
        if (in_last && in_count != '0)
            eff_n = in_count;
        rem_cur    = int'(n_q) - int'(beat_q) * CHARS_OUT;
        rem_nxt    = rem_cur - CHARS_OUT;
        final_beat = (state == LOADED) && (rem_cur <= CHARS_OUT);
        in_ready   = rst_n && ((state == EMPTY) || (final_beat && out_ready));
        in_hs      = in_valid && in_ready;
        out_hs     = out_valid && out_ready;
        beat_load  = make_beat(in_data, int'(eff_n), 0);
        beat_next  = make_beat(word_q, rem_nxt, int'(beat_q) + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            word_q    <= '0;
            n_q       <= '0;
            last_q    <= 1'b0;
            beat_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (in_hs) begin
            // A new word may replace the current one in the same cycle its final beat leaves.
            state                <= LOADED;
            word_q               <= in_data;
            n_q                  <= eff_n;
            last_q               <= in_last;
            beat_q               <= '0;
            out_valid            <= 1'b1;
            {out_keep, out_data} <= beat_load;
            out_last             <= in_last && (int'(eff_n) <= CHARS_OUT);
        end else if (out_hs) begin
            if (final_beat) begin
                state     <= EMPTY;
                beat_q    <= '0;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_keep  <= '0;
                out_last  <= 1'b0;
            end else begin
                beat_q               <= beat_q + BW'(1);
                {out_keep, out_data} <= beat_next;
                out_last             <= last_q && (rem_nxt <= CHARS_OUT);
            end
        end
    end

`ifdef GENE_UNPACK_STATS_EN
    logic [31:0] add_a, add_c, add_g, add_t;

    always_comb begin
        add_a = '0;
        add_c = '0;
        add_g = '0;
        add_t = '0;
        for (int i = 0; i < CHARS_OUT; i++) begin
            if (out_keep[i]) begin
                case (out_data[8*i +: 8])
                    8'h41:   add_a = add_a + 32'd1;
                    8'h43:   add_c = add_c + 32'd1;
                    8'h47:   add_g = add_g + 32'd1;
                    default: add_t = add_t + 32'd1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_c <= '0;
            cnt_g <= '0;
            cnt_t <= '0;
        end else if (stats_clr) begin
            cnt_a <= '0;
            cnt_c <= '0;
            cnt_g <= '0;
            cnt_t <= '0;
        end else if (out_hs) begin
            cnt_a <= cnt_a + add_a;
            cnt_c <= cnt_c + add_c;
            cnt_g <= cnt_g + add_g;
            cnt_t <= cnt_t + add_t;
        end
    end
`endif

endmodule

// File: doc/gene_unpack_stream.md
# gene_unpack_stream

Streaming 2-bit nucleotide decoder for the gene decompression path. It accepts packed words of `CODES_IN` 2-bit base codes over a valid/ready handshake. It expands each word into ASCII bases and emits `CHARS_OUT` characters per beat over a second valid/ready handshake. Partial final words are supported. It sits between the compressed-data reader and the byte-oriented output/UART path, and supersedes the fixed single-byte-to-four-character expander.

## Interface
Parameters:
- `CODES_IN`, 16: 2-bit codes per input word. Must be a multiple of `CHARS_OUT`.
- `CHARS_OUT`, 4: ASCII characters per output beat.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset. The block has one clock; reset is asynchronous and active-low.
- `in_valid`, input, 1: input word present.
- `in_ready`, output, 1: block accepts the word this cycle.
- `in_data`, input, 2*CODES_IN: packed codes. The first base is in the MSB pair.
- `in_last`, input, 1: this is the final word of the sequence.
- `in_count`, input, $clog2(CODES_IN+1): number of valid codes, taken from the MSB pair downward. Only sampled when `in_last`=1. A value of 0 means `CODES_IN`.
- `out_valid`, output, 1: beat present.
- `out_ready`, input, 1: sink accepts the beat.
- `out_data`, output, 8*CHARS_OUT: ASCII characters. The first character is in the MSB byte.
- `out_keep`, output, CHARS_OUT: byte-valid flags. Bit CHARS_OUT-1 corresponds to the MSB byte.
- `out_last`, output, 1: final beat of the sequence.

## Operation
- Code map: 00→0x41 'A', 01→0x43 'C', 10→0x47 'G', 11→0x54 'T'.
- Storage: one holding register containing the word, the remaining-code count and the last flag.
- Beat counter: range 0..CODES_IN/CHARS_OUT-1.
- States:
  - EMPTY → LOADED on input handshake.
  - LOADED → EMPTY on acceptance of the final beat of the word, unless a new word is accepted in the same cycle; in that case the state stays LOADED and the new word is loaded.
- `in_ready` = (state==EMPTY) | (final beat & `out_ready`). It is combinational and forced to 0 while `rst_n`=0.
- Beats per word:
  - Full word: CODES_IN/CHARS_OUT beats.
  - Last word: ceil(n/CHARS_OUT) beats, where n is `in_count` (0 treated as CODES_IN).
- `out_keep` on each beat: the top min(remaining, CHARS_OUT) bits are set. All other bits are 0.
- Characters whose keep bit is 0 are driven as 0x00.
- `out_last`: 1 only on the final beat of a word loaded with `in_last`=1.
- A beat advances only on `out_valid & out_ready`. While stalled, `out_data`, `out_keep` and `out_last` hold stable.
- `in_last`=0 with a nonzero `in_count`: `in_count` is ignored and the full word is emitted.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0.
  - State EMPTY, beat counter 0.
  - `in_ready`=0 while in reset and 1 from the first cycle after release.
- Latency: a word accepted at edge N produces its first beat valid after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle. Back-to-back words produce no bubble when `out_ready` is held high.
- Input throughput: one word per CODES_IN/CHARS_OUT cycles.
- Reset asserted mid-word: the held word is discarded and all outputs return to reset values immediately.

## Configuration
- `GENE_UNPACK_STATS_EN` defined:
  - Adds input `stats_clr` (1 bit).
  - Adds outputs `cnt_a`, `cnt_c`, `cnt_g`, `cnt_t` (32 bits each).
  - Each counter increments by the number of kept characters of its base on every output handshake.
  - Counters wrap modulo 2^32.
  - `stats_clr`=1 zeroes all counters synchronously. If a count and a clear occur in the same cycle, the clear wins.
  - Counters reset to 0 on `rst_n`.
- `GENE_UNPACK_STATS_EN` undefined: these ports and counters do not exist; the rest of the behaviour is identical.

## Test plan
All scenarios use the default parameters (CODES_IN=16, CHARS_OUT=4).
- Full word: `in_data`=0x1B1B1B1B, `in_last`=0, `out_ready`=1 → 4 beats of 0x41434754 with `out_keep`=1111 and `out_last`=0. `in_ready`=1 during the 4th beat.
- Back-to-back: two words, 0x00000000 then 0xFFFFFFFF, with `in_valid` held high → 8 consecutive beats: four of 0x41414141, then four of 0x54545454, with no gap.
- Partial last: `in_data`=0xE4000000, `in_last`=1, `in_count`=5 → beat 0x54474341 with keep 1111, then beat 0x41000000 with keep 1000 and `out_last`=1.
- Backpressure: `out_ready` toggles 1,0,0,1 during a word → `out_data` stays stable while stalled, no beat is lost or duplicated, and `in_ready` stays 0 until the final beat is accepted.
- Reset mid-word: assert `rst_n`=0 after beat 2 → `out_valid`=0 immediately. After release, a new word 0x1B1B1B1B emits exactly 4 correct beats.
- Stats (with `GENE_UNPACK_STATS_EN`): after the full-word scenario, each counter = 4. Pulse `stats_clr` → all counters = 0 on the next cycle.
